// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory
// over req/gnt/rvalid, buffers words in a 2-entry queue, drives IF/ID.
module fetch_stage #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_ip,
    input  logic        flush_ip,
    input  logic [31:0] next_pc_addr_ip,
    input  logic        next_pc_addr_valid_ip,
    output logic        instr_req_op,
    output logic [31:0] instr_addr_op,
    input  logic        instr_gnt_ip,
    input  logic        instr_rvalid_ip,
    input  logic [31:0] instr_rdata_ip,
    output logic [31:0] if_instr_op,
    output logic [31:0] if_pc_addr_op,
    output logic        if_valid_op
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] pend_pc;
    logic        pend_v;
    logic        kill;

    fq_entry_t   fq [2];
    fq_entry_t   head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fq_cnt;
    logic [1:0]  cnt_nxt;

    logic        redirect;
    logic [31:0] tgt;
    logic        rsp;
    logic        push;
    logic        pop;
    logic        space;
    logic        unused_lsb;

    assign redirect   = flush_ip & next_pc_addr_valid_ip;
    assign tgt        = {next_pc_addr_ip[31:2], 2'b00};
    assign unused_lsb = ^next_pc_addr_ip[1:0];

    // a response only counts while a request is outstanding
    assign rsp  = (state == S_WAIT) & instr_rvalid_ip;
    assign push = rsp & ~kill & ~redirect;
    assign pop  = ~redirect & ~stall_ip & (fq_cnt != 2'd0);
    assign head = fq[rd_ptr];

    // occupancy after this edge; a new request needs room for its word
    always_comb begin
        cnt_nxt = fq_cnt + {1'b0, push} - {1'b0, pop};
        if (redirect) cnt_nxt = 2'd0;
    end
    assign space = (cnt_nxt < 2'd2);

    // the address port is the PC itself; it only moves on grant
    assign instr_addr_op = pc;

    // request FSM, PC update, pending redirect target and kill flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            instr_req_op <= 1'b0;
            pc           <= BOOT_ADDR;
            req_pc       <= BOOT_ADDR;
            pend_pc      <= 32'd0;
            pend_v       <= 1'b0;
            kill         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (redirect) pc <= tgt;
                    if (space) begin
                        state        <= S_REQ;
                        instr_req_op <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (redirect) kill <= 1'b1;
                    if (instr_gnt_ip) begin
                        state        <= S_WAIT;
                        instr_req_op <= 1'b0;
                        req_pc       <= pc;
                        pend_v       <= 1'b0;
                        if (redirect)    pc <= tgt;
                        else if (pend_v) pc <= pend_pc;
                        else             pc <= pc + 32'd4;
                    end else if (redirect) begin
                        pend_pc <= tgt;
                        pend_v  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect) pc <= tgt;
                    if (instr_rvalid_ip) begin
                        kill <= 1'b0;
                        if (space) begin
                            state        <= S_REQ;
                            instr_req_op <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // 2-entry fetch queue, emptied by a redirect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fq[0]  <= '0;
            fq[1]  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            fq_cnt <= 2'd0;
        end else if (redirect) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            fq_cnt <= 2'd0;
        end else begin
            if (push) begin
                fq[wr_ptr] <= '{pc: req_pc, instr: instr_rdata_ip};
                wr_ptr     <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fq_cnt <= cnt_nxt;
        end
    end

    // IF/ID register: redirect beats stall, stall beats pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_instr_op   <= 32'd0;
            if_pc_addr_op <= 32'd0;
            if_valid_op   <= 1'b0;
        end else if (redirect) begin
            if_valid_op <= 1'b0;
        end else if (stall_ip) begin
            if_valid_op <= if_valid_op;
        end else if (fq_cnt != 2'd0) begin
            if_instr_op   <= head.instr;
            if_pc_addr_op <= head.pc;
            if_valid_op   <= 1'b1;
        end else begin
            if_valid_op <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder plus scoreboard of
// expected IF/ID words and expected request addresses.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall_ip = 1'b0;
    logic        flush_ip = 1'b0;
    logic [31:0] next_pc_addr_ip = 32'd0;
    logic        next_pc_addr_valid_ip = 1'b0;
    logic        instr_req_op;
    logic [31:0] instr_addr_op;
    logic        instr_gnt_ip = 1'b1;
    logic        instr_rvalid_ip = 1'b0;
    logic [31:0] instr_rdata_ip = 32'd0;
    logic [31:0] if_instr_op;
    logic [31:0] if_pc_addr_op;
    logic        if_valid_op;

    fetch_stage #(.BOOT_ADDR(32'h0000_0000)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall_ip              (stall_ip),
        .flush_ip              (flush_ip),
        .next_pc_addr_ip       (next_pc_addr_ip),
        .next_pc_addr_valid_ip (next_pc_addr_valid_ip),
        .instr_req_op          (instr_req_op),
        .instr_addr_op         (instr_addr_op),
        .instr_gnt_ip          (instr_gnt_ip),
        .instr_rvalid_ip       (instr_rvalid_ip),
        .instr_rdata_ip        (instr_rdata_ip),
        .if_instr_op           (if_instr_op),
        .if_pc_addr_op         (if_pc_addr_op),
        .if_valid_op           (if_valid_op)
    );

    initial forever #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb [$];
    exp_t        head;
    int          n_chk = 0;
    int          n_fail = 0;
    int          epoch = 0;
    int          cap_epoch = 0;
    int          hs_epoch = 0;
    int          rsp_epoch = 0;
    int          rv_delay = 0;
    int          rv_wait = 0;
    logic        rv_pend = 1'b0;
    logic        req_active = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] exp_req_addr = 32'd0;
    logic [31:0] hs_addr = 32'd0;
    logic        stall_q = 1'b0;
    logic        redir_q = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] prev_instr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'hA;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // memory responder and IF/ID scoreboard, all on the falling edge
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            sb.delete();
            epoch++;
            req_active   = 1'b0;
            exp_req_addr = 32'd0;
            stall_q      = 1'b0;
            redir_q      = 1'b0;
            prev_valid   = 1'b0;
            prev_pc      = 32'd0;
            prev_instr   = 32'd0;
        end
        if (instr_rvalid_ip && reset && rsp_epoch == epoch &&
            !(flush_ip && next_pc_addr_valid_ip))
            sb.push_back('{pc: hs_addr, instr: instr_rdata_ip});
        if (reset) begin
            if (redir_q) begin
                check("flush_valid", 32'(if_valid_op), 0);
            end else if (stall_q) begin
                check("stall_valid", 32'(if_valid_op), 32'(prev_valid));
                check("stall_pc", if_pc_addr_op, prev_pc);
                check("stall_instr", if_instr_op, prev_instr);
            end else if (if_valid_op) begin
                if (sb.size() == 0) begin
                    check("unexp_valid", 32'(if_valid_op), 0);
                end else begin
                    head = sb.pop_front();
                    check("if_pc", if_pc_addr_op, head.pc);
                    check("if_instr", if_instr_op, head.instr);
                end
            end
            if (req_active) begin
                check("req_hold", 32'(instr_req_op), 1);
                check("addr_hold", instr_addr_op, req_addr);
            end else if (instr_req_op) begin
                check("req_addr", instr_addr_op, exp_req_addr);
                req_addr     = exp_req_addr;
                exp_req_addr = exp_req_addr + 32'd4;
                cap_epoch    = epoch;
                req_active   = 1'b1;
            end
        end
        instr_rvalid_ip = 1'b0;
        if (rv_pend) begin
            if (rv_wait == 0) begin
                instr_rvalid_ip = 1'b1;
                instr_rdata_ip  = mem_word(hs_addr);
                rsp_epoch       = hs_epoch;
                rv_pend         = 1'b0;
            end else begin
                rv_wait--;
            end
        end
        if (reset && req_active && instr_req_op && instr_gnt_ip) begin
            hs_addr    = req_addr;
            hs_epoch   = cap_epoch;
            rv_pend    = 1'b1;
            rv_wait    = rv_delay;
            req_active = 1'b0;
        end
        if (reset && flush_ip && next_pc_addr_valid_ip) begin
            epoch++;
            sb.delete();
            exp_req_addr = {next_pc_addr_ip[31:2], 2'b00};
        end
        if (reset) begin
            stall_q    = stall_ip;
            redir_q    = flush_ip && next_pc_addr_valid_ip;
            prev_valid = if_valid_op;
            prev_pc    = if_pc_addr_op;
            prev_instr = if_instr_op;
        end
    end

    task automatic wait_grant(input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clock);
            hit = instr_req_op && instr_gnt_ip;
        end
        if (!hit) check(tag, 0, 1);
    endtask

    task automatic wait_req(input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clock);
            hit = instr_req_op;
        end
        if (!hit) check(tag, 0, 1);
    endtask

    task automatic wait_new_req(input string tag);
        bit low;
        low = !instr_req_op;
        for (int i = 0; i < 40 && !low; i++) begin
            @(negedge clock);
            low = !instr_req_op;
        end
        if (!low) check(tag, 0, 1);
        else wait_req(tag);
    endtask

    task automatic redirect(input logic [31:0] a, input logic stl);
        flush_ip              = 1'b1;
        next_pc_addr_ip       = a;
        next_pc_addr_valid_ip = 1'b1;
        stall_ip              = stl;
        @(posedge clock);
        #1;
        flush_ip              = 1'b0;
        next_pc_addr_valid_ip = 1'b0;
        stall_ip              = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_req", 32'(instr_req_op), 0);
        check("rst_addr", instr_addr_op, 32'h0);
        check("rst_instr", if_instr_op, 0);
        check("rst_pc", if_pc_addr_op, 0);
        check("rst_valid", 32'(if_valid_op), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // boot fetch, zero-wait memory
        @(posedge clock);
        #1;
        check("first_req", 32'(instr_req_op), 1);
        repeat (3) @(posedge clock);
        #1;
        check("t1_v0", 32'(if_valid_op), 1);
        check("t1_pc0", if_pc_addr_op, 32'h0);
        check("t1_i0", if_instr_op, 32'hA);
        @(posedge clock);
        #1;
        check("t1_gap0", 32'(if_valid_op), 0);
        @(posedge clock);
        #1;
        check("t1_v1", 32'(if_valid_op), 1);
        check("t1_pc1", if_pc_addr_op, 32'h4);
        check("t1_i1", if_instr_op, 32'hB);
        @(posedge clock);
        #1;
        check("t1_gap1", 32'(if_valid_op), 0);
        @(posedge clock);
        #1;
        check("t1_v2", 32'(if_valid_op), 1);
        check("t1_pc2", if_pc_addr_op, 32'h8);
        check("t1_i2", if_instr_op, 32'hC);

        // stall fills the queue, then requests stop
        stall_ip = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("stall_noreq", 32'(instr_req_op), 0);
        check("stall_fill", 32'(sb.size()), 2);
        stall_ip = 1'b0;
        repeat (6) @(posedge clock);
        #1;

        // flush without a valid target is ignored
        flush_ip        = 1'b1;
        next_pc_addr_ip = 32'h500;
        @(posedge clock);
        #1;
        flush_ip = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // redirect while waiting on a slow response
        rv_delay = 2;
        wait_grant("t3_grant");
        @(posedge clock);
        #1;
        rv_delay = 0;
        redirect(32'h103, 1'b0);
        check("t3_valid", 32'(if_valid_op), 0);
        wait_req("t3_req");
        check("t3_addr", instr_addr_op, 32'h100);
        repeat (4) @(posedge clock);
        #1;

        // redirect while a request is held without grant
        instr_gnt_ip = 1'b0;
        for (int i = 0; i < 10 && !instr_req_op; i++) begin
            @(posedge clock);
            #1;
        end
        check("t4_req", 32'(instr_req_op), 1);
        redirect(32'h200, 1'b0);
        check("t4_valid", 32'(if_valid_op), 0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        instr_gnt_ip = 1'b1;
        wait_new_req("t4_req2");
        check("t4_addr", instr_addr_op, 32'h200);
        repeat (4) @(posedge clock);
        #1;

        // redirect, rvalid and stall in the same cycle
        wait_grant("t5_grant");
        @(posedge clock);
        #1;
        redirect(32'h300, 1'b1);
        check("t5_valid", 32'(if_valid_op), 0);
        check("t5_req", 32'(instr_req_op), 1);
        check("t5_addr", instr_addr_op, 32'h300);
        repeat (6) @(posedge clock);
        #1;

        // async reset while a request is outstanding
        rv_delay = 2;
        wait_grant("t6_grant");
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("t6_req", 32'(instr_req_op), 0);
        check("t6_addr", instr_addr_op, 32'h0);
        check("t6_instr", if_instr_op, 0);
        check("t6_pc", if_pc_addr_op, 0);
        check("t6_valid", 32'(if_valid_op), 0);
        @(posedge clock);
        #1;
        reset    = 1'b1;
        rv_delay = 0;
        repeat (8) @(posedge clock);
        #1;

        // PC wraps past the top of the address space
        redirect(32'hFFFF_FFFC, 1'b0);
        wait_req("t7_req");
        check("t7_addr", instr_addr_op, 32'hFFFF_FFFC);
        wait_new_req("t7_req2");
        check("t7_wrap", instr_addr_op, 32'h0);
        repeat (8) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
